// File: rtl/servo_step_ctrl_pkg.sv
// Shared types and helpers for the servo-arm button/PWM path.
package servo_step_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_UP,
      PRESS_DN,
      REPEAT_UP,
      REPEAT_DN
   } step_state_t;

   // Smallest n such that 2**n >= v (0 for v <= 1).
   function automatic int unsigned ceillog2(input longint unsigned v);
      int unsigned     n;
      longint unsigned p;
      n = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         n = n + 1;
      end
      return n;
   endfunction

   // Counter width able to hold every value up to max(a,b)-1, at least one bit.
   function automatic int unsigned cnt_width(input longint unsigned a,
                                             input longint unsigned b);
      int unsigned n;
      n = ceillog2((a > b) ? a : b);
      return (n == 0) ? 1 : n;
   endfunction

endpackage

// File: rtl/servo_step_ctrl_if.sv
// Button levels in, duty setpoint and status out.
interface servo_step_ctrl_if #(
   parameter int unsigned W = 8
);
   logic         btn_up;
   logic         btn_down;
   logic         btn_center;
   logic [W-1:0] duty_out;
   logic         at_min;
   logic         at_max;
   logic         step_pulse;

   modport master (
      output btn_up, btn_down, btn_center,
      input  duty_out, at_min, at_max, step_pulse
   );

   modport slave (
      input  btn_up, btn_down, btn_center,
      output duty_out, at_min, at_max, step_pulse
   );
endinterface

// File: rtl/servo_step_ctrl_hold_timer.sv
// Hold/repeat timer: synchronous clear, enable, saturating count, match flags.
module servo_step_ctrl_hold_timer #(
   parameter int unsigned HOLD_CYC   = 50_000_000,
   parameter int unsigned REPEAT_CYC = 5_000_000,
   parameter int unsigned CW         = 26
) (
   input  logic clk,
   input  logic rst_s_p,
   input  logic i_clr,
   input  logic i_en,
   output logic o_match_hold,
   output logic o_match_rep
);

   logic [CW-1:0] r_cnt;

   // Count while enabled; hold at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst_s_p || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_match_hold = (r_cnt == CW'(HOLD_CYC - 1));
   assign o_match_rep  = (r_cnt == CW'(REPEAT_CYC - 1));

endmodule

// File: rtl/servo_step_ctrl.sv
// Saturating duty setpoint driven by debounced up/down/center buttons,
// with single-step presses and auto-repeat after a hold delay.
module servo_step_ctrl
   import servo_step_ctrl_pkg::*;
#(
   parameter int unsigned W          = 8,
   parameter int unsigned DUTY_MIN   = 50,
   parameter int unsigned DUTY_MAX   = 250,
   parameter int unsigned DUTY_HOME  = 150,
   parameter int unsigned STEP       = 5,
   parameter int unsigned HOLD_CYC   = 50_000_000,
   parameter int unsigned REPEAT_CYC = 5_000_000
) (
   input  logic               clk,
   input  logic               rst_s_p,
   servo_step_ctrl_if.slave   bus
);

   localparam int unsigned CW = cnt_width(HOLD_CYC, REPEAT_CYC);

   step_state_t  r_state, w_state_nxt;
   logic [W-1:0] r_duty, w_duty_nxt;
   logic         r_step_pulse;
   logic         r_up_q, r_down_q, r_ctr_q;
   logic         w_rise_up, w_rise_dn, w_rise_ctr;
   logic         w_do_up, w_do_dn, w_do_home;
   logic         w_cnt_clr, w_cnt_en;
   logic         w_match_hold, w_match_rep;
   logic [W:0]   w_up_sum;
   logic [W-1:0] w_up_val, w_dn_val;

   assign w_rise_up  = bus.btn_up     && !r_up_q;
   assign w_rise_dn  = bus.btn_down   && !r_down_q;
   assign w_rise_ctr = bus.btn_center && !r_ctr_q;

   // Saturating step targets, evaluated one bit wider to avoid wrap.
   assign w_up_sum = {1'b0, r_duty} + (W+1)'(STEP);
   assign w_up_val = (w_up_sum > (W+1)'(DUTY_MAX)) ? W'(DUTY_MAX) : w_up_sum[W-1:0];
   assign w_dn_val = ({1'b0, r_duty} < (W+1)'(DUTY_MIN + STEP)) ? W'(DUTY_MIN)
                                                                : (r_duty - W'(STEP));

   servo_step_ctrl_hold_timer #(
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .CW         (CW)
   ) u_hold_timer (
      .clk          (clk),
      .rst_s_p      (rst_s_p),
      .i_clr        (w_cnt_clr),
      .i_en         (w_cnt_en),
      .o_match_hold (w_match_hold),
      .o_match_rep  (w_match_rep)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst_s_p) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state and step requests: center rise, then both-held, then per-state handling.
   // A held-direction release coinciding with the opposite rise is handled as a fresh press.
   always_comb begin
      w_state_nxt = r_state;
      w_do_up     = 1'b0;
      w_do_dn     = 1'b0;
      w_do_home   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;
      if (w_rise_ctr) begin
         w_do_home   = 1'b1;
         w_state_nxt = IDLE;
         w_cnt_clr   = 1'b1;
      end else if (bus.btn_up && bus.btn_down) begin
         w_state_nxt = IDLE;
         w_cnt_clr   = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_cnt_clr = 1'b1;
               if (w_rise_up) begin
                  w_do_up     = 1'b1;
                  w_state_nxt = PRESS_UP;
               end else if (w_rise_dn) begin
                  w_do_dn     = 1'b1;
                  w_state_nxt = PRESS_DN;
               end
            end
            PRESS_UP, REPEAT_UP: begin
               if (!bus.btn_up) begin
                  w_cnt_clr   = 1'b1;
                  w_do_dn     = w_rise_dn;
                  w_state_nxt = w_rise_dn ? PRESS_DN : IDLE;
               end else if ((r_state == PRESS_UP) ? w_match_hold : w_match_rep) begin
                  w_do_up     = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = REPEAT_UP;
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
            PRESS_DN, REPEAT_DN: begin
               if (!bus.btn_down) begin
                  w_cnt_clr   = 1'b1;
                  w_do_up     = w_rise_up;
                  w_state_nxt = w_rise_up ? PRESS_UP : IDLE;
               end else if ((r_state == PRESS_DN) ? w_match_hold : w_match_rep) begin
                  w_do_dn     = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = REPEAT_DN;
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_clr   = 1'b1;
            end
         endcase
      end
   end

   // Select the next setpoint from the requested action.
   always_comb begin
      w_duty_nxt = r_duty;
      if (w_do_home)    w_duty_nxt = W'(DUTY_HOME);
      else if (w_do_up) w_duty_nxt = w_up_val;
      else if (w_do_dn) w_duty_nxt = w_dn_val;
   end

   // Setpoint, change strobe and edge history; reset seeds history from live
   // levels so a button held through reset is not taken as a new press.
   always_ff @(posedge clk) begin
      if (rst_s_p) begin
         r_duty       <= W'(DUTY_HOME);
         r_step_pulse <= 1'b0;
      end else begin
         r_duty       <= w_duty_nxt;
         r_step_pulse <= (w_duty_nxt != r_duty);
      end
      r_up_q   <= bus.btn_up;
      r_down_q <= bus.btn_down;
      r_ctr_q  <= bus.btn_center;
   end

   assign bus.duty_out   = r_duty;
   assign bus.step_pulse = r_step_pulse;
   assign bus.at_min     = (r_duty == W'(DUTY_MIN));
   assign bus.at_max     = (r_duty == W'(DUTY_MAX));

endmodule

// File: tb/tb_servo_step_ctrl.sv
// Bench for servo_step_ctrl: directed scenarios with literal expectations plus
// random button traffic, all checked every cycle against a press-age model.
module tb_servo_step_ctrl;

   localparam int W    = 8;
   localparam int MIN  = 52;   // off the STEP grid so both clamps are exercised
   localparam int MAX  = 248;
   localparam int HOME = 150;
   localparam int STEP = 5;
   localparam int HOLD = 10;
   localparam int REP  = 4;

   logic clk = 1'b0;
   logic rst_s_p;
   int   total = 0;
   int   bad   = 0;
   bit   chk_on = 1'b0;

   servo_step_ctrl_if #(.W(W)) ifc ();

   servo_step_ctrl #(
      .W          (W),
      .DUTY_MIN   (MIN),
      .DUTY_MAX   (MAX),
      .DUTY_HOME  (HOME),
      .STEP       (STEP),
      .HOLD_CYC   (HOLD),
      .REPEAT_CYC (REP)
   ) dut (
      .clk     (clk),
      .rst_s_p (rst_s_p),
      .bus     (ifc)
   );

   always #5 clk = ~clk;

   // Reference model: tracks which button is being held and for how many
   // cycles since its press; steps at age 0, HOLD, HOLD+REP, HOLD+2*REP...
   int m_duty = HOME;
   bit m_pulse = 1'b0;
   int m_act = 0;      // 0 none, 1 up, 2 down
   int m_age = 0;
   bit pu = 1'b0, pd = 1'b0, pc = 1'b0;

   function automatic bit due(input int age);
      return (age == HOLD) || ((age > HOLD) && ((age - HOLD) % REP == 0));
   endfunction
   function automatic int up(input int x);
      return (x + STEP > MAX) ? MAX : x + STEP;
   endfunction
   function automatic int dn(input int x);
      return (x - STEP < MIN) ? MIN : x - STEP;
   endfunction

   always @(posedge clk) begin
      bit u, d, c;
      int nd;
      u = ifc.btn_up; d = ifc.btn_down; c = ifc.btn_center;
      if (rst_s_p) begin
         m_duty = HOME; m_pulse = 1'b0; m_act = 0; m_age = 0;
      end else begin
         nd = m_duty;
         if (c && !pc) begin
            nd = HOME; m_act = 0;
         end else if (u && d) begin
            m_act = 0;
         end else if (m_act == 1 && u) begin
            m_age++; if (due(m_age)) nd = up(nd);
         end else if (m_act == 2 && d) begin
            m_age++; if (due(m_age)) nd = dn(nd);
         end else begin
            m_act = 0;
            if (u && !pu)      begin m_act = 1; m_age = 0; nd = up(nd); end
            else if (d && !pd) begin m_act = 2; m_age = 0; nd = dn(nd); end
         end
         m_pulse = (nd != m_duty);
         m_duty  = nd;
      end
      pu = u; pd = d; pc = c;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("duty", int'(ifc.duty_out), m_duty);
         chk("pulse", int'(ifc.step_pulse), int'(m_pulse));
         chk("at_min", int'(ifc.at_min), int'(m_duty == MIN));
         chk("at_max", int'(ifc.at_max), int'(m_duty == MAX));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic btn(input bit u, input bit d, input bit c);
      ifc.btn_up = u; ifc.btn_down = d; ifc.btn_center = c;
   endtask

   task automatic press_up();
      btn(1, 0, 0); tick(1); btn(0, 0, 0); tick(1);
   endtask
   task automatic press_dn();
      btn(0, 1, 0); tick(1); btn(0, 0, 0); tick(1);
   endtask

   initial begin
      rst_s_p = 1'b1;
      btn(0, 0, 0);
      tick(2);
      chk_on = 1'b1;
      chk("rst_duty", int'(ifc.duty_out), 150);
      chk("rst_pulse", int'(ifc.step_pulse), 0);
      chk("rst_flags", int'({ifc.at_min, ifc.at_max}), 0);
      rst_s_p = 1'b0;
      tick(1);

      // Short press: one step only.
      btn(1, 0, 0); tick(1);
      chk("p1_duty", int'(ifc.duty_out), 155);
      chk("p1_pulse", int'(ifc.step_pulse), 1);
      tick(1);
      chk("p1_pulse_off", int'(ifc.step_pulse), 0);
      tick(1); btn(0, 0, 0); tick(3);
      chk("p1_hold", int'(ifc.duty_out), 155);

      // Hold: step at rise, at rise+HOLD, then every REP.
      btn(1, 0, 0); tick(1);
      chk("h_rise", int'(ifc.duty_out), 160);
      tick(9);
      chk("h_wait", int'(ifc.duty_out), 160);
      tick(1);
      chk("h_first", int'(ifc.duty_out), 165);
      chk("h_first_pulse", int'(ifc.step_pulse), 1);
      tick(4); chk("h_rep1", int'(ifc.duty_out), 170);
      tick(4); chk("h_rep2", int'(ifc.duty_out), 175);
      tick(4); chk("h_rep3", int'(ifc.duty_out), 180);
      btn(0, 0, 0); tick(6);
      chk("h_release", int'(ifc.duty_out), 180);

      // Climb to the top clamp.
      repeat (14) press_up();
      chk("max_duty", int'(ifc.duty_out), 248);
      chk("max_flag", int'(ifc.at_max), 1);
      btn(1, 0, 0); tick(1);
      chk("max_nopulse", int'(ifc.step_pulse), 0);
      chk("max_stay", int'(ifc.duty_out), 248);
      btn(0, 0, 0); tick(1);

      // Center recall; holding center does nothing further.
      btn(0, 0, 1); tick(1);
      chk("ctr_duty", int'(ifc.duty_out), 150);
      chk("ctr_pulse", int'(ifc.step_pulse), 1);
      tick(3); btn(0, 0, 0); tick(1);

      // Descend to the bottom clamp.
      repeat (20) press_dn();
      chk("min_duty", int'(ifc.duty_out), 52);
      chk("min_flag", int'(ifc.at_min), 1);
      btn(0, 1, 0); tick(1);
      chk("min_nopulse", int'(ifc.step_pulse), 0);
      chk("min_nowrap", int'(ifc.duty_out), 52);
      btn(0, 0, 0); tick(1);

      // Both up and down: no step; dropping down alone is not a press.
      btn(0, 0, 1); tick(1); btn(0, 0, 0); tick(1);
      btn(1, 1, 0); tick(20);
      chk("both_duty", int'(ifc.duty_out), 150);
      btn(1, 0, 0); tick(3);
      chk("both_rel", int'(ifc.duty_out), 150);
      btn(0, 0, 0); tick(1);

      // Reset in the middle of a repeating hold.
      btn(1, 0, 0); tick(12);
      chk("mid_pre", int'(ifc.duty_out), 160);
      rst_s_p = 1'b1; tick(1); rst_s_p = 1'b0;
      chk("mid_rst", int'(ifc.duty_out), 150);
      tick(15);
      chk("mid_held", int'(ifc.duty_out), 150);
      btn(0, 0, 0); tick(1);
      btn(1, 0, 0); tick(1);
      chk("mid_repress", int'(ifc.duty_out), 155);
      btn(0, 0, 0); tick(2);

      // Random button traffic, including long holds and occasional reset.
      for (int s = 0; s < 250; s++) begin
         int r;
         r = int'($urandom_range(0, 9));
         ifc.btn_up     = (r < 4) || (r == 8);
         ifc.btn_down   = (r >= 4 && r < 8) || (r == 8);
         ifc.btn_center = ($urandom_range(0, 7) == 0);
         rst_s_p        = ($urandom_range(0, 49) == 0);
         tick(int'($urandom_range(1, 30)));
         rst_s_p = 1'b0;
      end
      btn(0, 0, 0); tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
